// File: rtl/imm_ext_ctrl.sv
// Decode-stage immediate controller: opcode decode for the extender plus a
// 2-entry FIFO toward ID/EX. Optional lui handling under `IMM_LUI_EN`.
module imm_ext_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      INSTR,
  output logic             EXT_SEL,
  output logic [15:0]      IM16,
  input  logic [31:0]      EXT_OUT,
  input  logic             FLUSH,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [31:0]      IMM_OUT,
  output logic [1:0]       IMM_KIND,
  output logic [4:0]       RT_OUT,
  output logic [CNT_W-1:0] STALL_CNT
);

  localparam logic [1:0] KIND_NONE  = 2'd0;
  localparam logic [1:0] KIND_ZERO  = 2'd1;
  localparam logic [1:0] KIND_SIGN  = 2'd2;
  localparam logic [1:0] KIND_UPPER = 2'd3;

  logic [5:0]  opcode_p0;
  logic [1:0]  kind_p0;
  logic [31:0] imm_p0;
  logic        unused_rs;

  logic [31:0] imm_p1  [2];
  logic [1:0]  kind_p1 [2];
  logic [4:0]  rt_p1   [2];
  logic        head_p1;
  logic        tail_p1;
  logic [1:0]  count_p1;
  logic        push;
  logic        pop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Stage p0: combinational decode, independent of IN_VALID
  assign opcode_p0 = INSTR[31:26];
  assign IM16      = INSTR[15:0];
  assign unused_rs = ^INSTR[25:21];

  always_comb begin
    EXT_SEL = 1'b0;
    kind_p0 = KIND_NONE;
    case (opcode_p0)
      6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: begin
        EXT_SEL = 1'b1;
        kind_p0 = KIND_SIGN;
      end
      6'h0C, 6'h0D, 6'h0E: kind_p0 = KIND_ZERO;
`ifdef IMM_LUI_EN
      6'h0F: kind_p0 = KIND_UPPER;
`else
      6'h0F: kind_p0 = KIND_ZERO;
`endif
      default: kind_p0 = KIND_NONE;
    endcase
  end

  // lui bypasses the extender entirely; unknown opcodes store a clean zero
  always_comb begin
    case (kind_p0)
      KIND_NONE:  imm_p0 = 32'h0;
      KIND_UPPER: imm_p0 = {INSTR[15:0], 16'h0};
      default:    imm_p0 = EXT_OUT;
    endcase
  end

  // Stage p1: 2-entry FIFO, head entry drives the outputs
  assign IN_READY  = (count_p1 != 2'd2);
  assign OUT_VALID = (count_p1 != 2'd0);
  assign push      = IN_VALID & IN_READY;
  assign pop       = OUT_VALID & OUT_READY;
  assign IMM_OUT   = imm_p1[head_p1];
  assign IMM_KIND  = kind_p1[head_p1];
  assign RT_OUT    = rt_p1[head_p1];

  always_ff @(posedge clk) begin
    if (reset) begin
      count_p1  <= 2'd0;
      head_p1   <= 1'b0;
      tail_p1   <= 1'b0;
      STALL_CNT <= '0;
      for (int i = 0; i < 2; i++) begin
        imm_p1[i]  <= 32'h0;
        kind_p1[i] <= KIND_NONE;
        rt_p1[i]   <= 5'd0;
      end
    end else begin
      if (OUT_VALID && !OUT_READY && !FLUSH)
        STALL_CNT <= sat_inc(STALL_CNT);
      if (FLUSH) begin
        count_p1 <= 2'd0;
        head_p1  <= 1'b0;
        tail_p1  <= 1'b0;
      end else begin
        if (push) begin
          imm_p1[tail_p1]  <= imm_p0;
          kind_p1[tail_p1] <= kind_p0;
          rt_p1[tail_p1]   <= INSTR[20:16];
          tail_p1          <= ~tail_p1;
        end
        if (pop)
          head_p1 <= ~head_p1;
        case ({push, pop})
          2'b10:   count_p1 <= count_p1 + 2'd1;
          2'b01:   count_p1 <= count_p1 - 2'd1;
          default: count_p1 <= count_p1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// Directed bench for imm_ext_ctrl; narrow stall counter so saturation is reachable.
module tb_imm_ext_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             IN_VALID;
  logic             IN_READY;
  logic [31:0]      INSTR;
  logic             EXT_SEL;
  logic [15:0]      IM16;
  logic [31:0]      EXT_OUT;
  logic             FLUSH;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [31:0]      IMM_OUT;
  logic [1:0]       IMM_KIND;
  logic [4:0]       RT_OUT;
  logic [CNT_W-1:0] STALL_CNT;

  int n_checks = 0;
  int n_pass   = 0;

  imm_ext_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INSTR(INSTR), .EXT_SEL(EXT_SEL), .IM16(IM16), .EXT_OUT(EXT_OUT),
    .FLUSH(FLUSH), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .IMM_OUT(IMM_OUT), .IMM_KIND(IMM_KIND), .RT_OUT(RT_OUT),
    .STALL_CNT(STALL_CNT)
  );

  always #5 clk = ~clk;

  // Behavioural sign/zero extender sitting outside the block
  assign EXT_OUT = EXT_SEL ? {{16{IM16[15]}}, IM16} : {16'h0, IM16};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [15:0] imm);
    return {op, 5'd0, rt, imm};
  endfunction

  task automatic chk_head(input string tag, input logic [31:0] imm,
                          input logic [1:0] kind, input logic [4:0] rt);
    chk({tag, "_vld"},  {31'h0, OUT_VALID}, 32'h1);
    chk({tag, "_imm"},  IMM_OUT, imm);
    chk({tag, "_kind"}, {30'h0, IMM_KIND}, {30'h0, kind});
    chk({tag, "_rt"},   {27'h0, RT_OUT}, {27'h0, rt});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ovld"}, {31'h0, OUT_VALID}, 32'h0);
    chk({tag, "_irdy"}, {31'h0, IN_READY}, 32'h1);
  endtask

  initial begin
    reset = 1'b1; IN_VALID = 1'b0; INSTR = 32'h0; FLUSH = 1'b0; OUT_READY = 1'b0;
    tick(); tick();
    chk_idle("rst");
    chk("rst_imm", IMM_OUT, 32'h0);
    chk("rst_kind", {30'h0, IMM_KIND}, 32'h0);
    chk("rst_rt", {27'h0, RT_OUT}, 32'h0);
    chk("rst_stall", {28'h0, STALL_CNT}, 32'h0);
    reset = 1'b0;
    tick();

    // addi sign-extends
    INSTR = mk(6'h08, 5'd2, 16'hFFFC); IN_VALID = 1'b1; OUT_READY = 1'b1; #1;
    chk("addi_extsel", {31'h0, EXT_SEL}, 32'h1);
    tick(); IN_VALID = 1'b0;
    chk_head("addi", 32'hFFFF_FFFC, 2'd2, 5'd2);
    tick();
    chk_idle("addi_pop");

    // ori zero-extends, then R-type pushed while ori pops
    INSTR = mk(6'h0D, 5'd3, 16'h8001); IN_VALID = 1'b1; #1;
    chk("ori_extsel", {31'h0, EXT_SEL}, 32'h0);
    tick();
    INSTR = 32'h0122_4020;
    chk_head("ori", 32'h0000_8001, 2'd1, 5'd3);
    tick(); IN_VALID = 1'b0;
    chk_head("rtype", 32'h0, 2'd0, 5'd2);
    tick();
    chk_idle("rtype_pop");

    // back-pressure: third instruction held until release
    OUT_READY = 1'b0; IN_VALID = 1'b1; INSTR = mk(6'h09, 5'd5, 16'h0010);
    tick();
    chk("bp1_irdy", {31'h0, IN_READY}, 32'h1);
    chk("bp1_stall", {28'h0, STALL_CNT}, 32'h0);
    INSTR = mk(6'h0A, 5'd6, 16'h8000);
    tick();
    chk("bp2_irdy", {31'h0, IN_READY}, 32'h0);
    chk("bp2_stall", {28'h0, STALL_CNT}, 32'h1);
    INSTR = mk(6'h0E, 5'd7, 16'hABCD);
    tick();
    chk("bp3_irdy", {31'h0, IN_READY}, 32'h0);
    chk("bp3_stall", {28'h0, STALL_CNT}, 32'h2);
    chk_head("bpA", 32'h0000_0010, 2'd2, 5'd5);
    OUT_READY = 1'b1;
    tick();
    chk_head("bpB", 32'hFFFF_8000, 2'd2, 5'd6);
    chk("bpB_irdy", {31'h0, IN_READY}, 32'h1);
    tick(); IN_VALID = 1'b0;
    chk_head("bpC", 32'h0000_ABCD, 2'd1, 5'd7);
    tick();
    chk_idle("bp_done");
    chk("bp_stall", {28'h0, STALL_CNT}, 32'h2);

    // full buffer drains across pointer wrap while a new entry waits
    OUT_READY = 1'b0; IN_VALID = 1'b1; INSTR = mk(6'h23, 5'd8, 16'h0004);
    tick();
    INSTR = mk(6'h2B, 5'd9, 16'hFFF0);
    tick();
    INSTR = mk(6'h04, 5'd10, 16'h0001); OUT_READY = 1'b1;
    chk_head("wrapD", 32'h0000_0004, 2'd2, 5'd8);
    tick();
    chk_head("wrapE", 32'hFFFF_FFF0, 2'd2, 5'd9);
    tick(); IN_VALID = 1'b0;
    chk_head("wrapF", 32'h0000_0001, 2'd2, 5'd10);
    tick();
    chk_idle("wrap_done");
    chk("wrap_stall", {28'h0, STALL_CNT}, 32'h3);

    // flush with full buffer and a pending push
    OUT_READY = 1'b0; IN_VALID = 1'b1; INSTR = mk(6'h0C, 5'd11, 16'h00FF);
    tick();
    INSTR = mk(6'h05, 5'd12, 16'h7FFF);
    tick();
    INSTR = mk(6'h08, 5'd13, 16'h0055); FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0; IN_VALID = 1'b0;
    chk_idle("flush");
    chk("flush_stall", {28'h0, STALL_CNT}, 32'h4);
    OUT_READY = 1'b1;
    tick();
    chk("flush_nostore", {31'h0, OUT_VALID}, 32'h0);

    // lui, then hold stalled long enough to saturate, then reset mid-stall
    OUT_READY = 1'b0; IN_VALID = 1'b1; INSTR = mk(6'h0F, 5'd14, 16'h1234); #1;
    chk("lui_extsel", {31'h0, EXT_SEL}, 32'h0);
    tick(); IN_VALID = 1'b0;
`ifdef IMM_LUI_EN
    chk_head("lui", 32'h1234_0000, 2'd3, 5'd14);
`else
    chk_head("lui", 32'h0000_1234, 2'd1, 5'd14);
`endif
    tick();
    chk("stall_mid", {28'h0, STALL_CNT}, 32'h5);
    for (int i = 0; i < 15; i++) tick();
    chk("stall_sat", {28'h0, STALL_CNT}, 32'hF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("rst2");
    chk("rst2_imm", IMM_OUT, 32'h0);
    chk("rst2_kind", {30'h0, IMM_KIND}, 32'h0);
    chk("rst2_rt", {27'h0, RT_OUT}, 32'h0);
    chk("rst2_stall", {28'h0, STALL_CNT}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
